// File: rtl/alu_pkg.sv
// ALU op encodings and default widths shared by the ALU arbiter and its users.
package alu_pkg;
   localparam int ALU_W   = 32;
   localparam int ALU_OPW = 4;

   localparam logic [3:0] ADD  = 4'd0;
   localparam logic [3:0] SUB  = 4'd1;
   localparam logic [3:0] XOR  = 4'd2;
   localparam logic [3:0] OR   = 4'd3;
   localparam logic [3:0] AND  = 4'd4;
   localparam logic [3:0] SLL  = 4'd5;
   localparam logic [3:0] SRL  = 4'd6;
   localparam logic [3:0] SRA  = 4'd7;
   localparam logic [3:0] SLT  = 4'd8;
   localparam logic [3:0] SLTU = 4'd9;
endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry response buffer: captures ALU result/zero on load, clears its valid on drain.
module alu_rsp_slot #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         rready,
   input  logic [W-1:0] c_in,
   input  logic         z_in,
   output logic         rvalid,
   output logic [W-1:0] c,
   output logic         z
);
   // Load wins over drain so a same-cycle consume and refill leaves no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= 1'b0;
         c      <= '0;
         z      <= 1'b0;
      end else if (load) begin
         rvalid <= 1'b1;
         c      <= c_in;
         z      <= z_in;
      end else if (rvalid && rready) begin
         rvalid <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters with per-requester result slots.
// Optional perf counters are enabled with the ALU_ARB_PERF_EN macro.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int W   = ALU_W,
   parameter int OPW = ALU_OPW
`ifdef ALU_ARB_PERF_EN
   , parameter int CNTW = 16
`endif
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           r0_valid,
   output logic           r0_ready,
   input  logic [W-1:0]   r0_a,
   input  logic [W-1:0]   r0_b,
   input  logic [OPW-1:0] r0_op,
   output logic           r0_rvalid,
   input  logic           r0_rready,
   output logic [W-1:0]   r0_c,
   output logic           r0_z,
   input  logic           r1_valid,
   output logic           r1_ready,
   input  logic [W-1:0]   r1_a,
   input  logic [W-1:0]   r1_b,
   input  logic [OPW-1:0] r1_op,
   output logic           r1_rvalid,
   input  logic           r1_rready,
   output logic [W-1:0]   r1_c,
   output logic           r1_z,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic [OPW-1:0] alu_op,
   input  logic [W-1:0]   alu_c,
   input  logic           alu_z
`ifdef ALU_ARB_PERF_EN
   , output logic [CNTW-1:0] perf_gnt0
   , output logic [CNTW-1:0] perf_gnt1
   , output logic [CNTW-1:0] perf_conf
`endif
);
   logic ptr;
   logic elig0, elig1;
   logic gnt0, gnt1;

   // A requester may be granted while its slot is draining this same cycle; nothing is granted in reset.
   always_comb begin
      elig0 = rst_n && r0_valid && (!r0_rvalid || r0_rready);
      elig1 = rst_n && r1_valid && (!r1_rvalid || r1_rready);
      gnt0  = elig0 && (!elig1 || !ptr);
      gnt1  = elig1 && (!elig0 ||  ptr);
   end

   assign r0_ready = gnt0;
   assign r1_ready = gnt1;

   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = OPW'(ADD);
      if (gnt0) begin
         alu_a  = r0_a;
         alu_b  = r0_b;
         alu_op = r0_op;
      end else if (gnt1) begin
         alu_a  = r1_a;
         alu_b  = r1_b;
         alu_op = r1_op;
      end
   end

   // Priority moves to the requester that was not just served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (gnt0) begin
         ptr <= 1'b1;
      end else if (gnt1) begin
         ptr <= 1'b0;
      end
   end

   alu_rsp_slot #(.W(W)) u_slot0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (gnt0),
      .rready (r0_rready),
      .c_in   (alu_c),
      .z_in   (alu_z),
      .rvalid (r0_rvalid),
      .c      (r0_c),
      .z      (r0_z)
   );

   alu_rsp_slot #(.W(W)) u_slot1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (gnt1),
      .rready (r1_rready),
      .c_in   (alu_c),
      .z_in   (alu_z),
      .rvalid (r1_rvalid),
      .c      (r1_c),
      .z      (r1_z)
   );

`ifdef ALU_ARB_PERF_EN
   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + CNTW'(1);
   endfunction

   // Contention counts cycles where both wanted the ALU but exactly one got it, slot-blocked included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_gnt0 <= '0;
         perf_gnt1 <= '0;
         perf_conf <= '0;
      end else begin
         if (gnt0) perf_gnt0 <= sat_inc(perf_gnt0);
         if (gnt1) perf_gnt1 <= sat_inc(perf_gnt1);
         if (r0_valid && r1_valid && (gnt0 != gnt1)) perf_conf <= sat_inc(perf_conf);
      end
   end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed spec scenarios plus a constrained-random run
// against a transaction-level model. Perf checks compile only with ALU_ARB_PERF_EN.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_valid, r0_ready, r0_rvalid, r0_rready, r0_z;
   logic        r1_valid, r1_ready, r1_rvalid, r1_rready, r1_z;
   logic [31:0] r0_a, r0_b, r0_c, r1_a, r1_b, r1_c;
   logic [3:0]  r0_op, r1_op;
   logic [31:0] alu_a, alu_b, alu_c;
   logic [3:0]  alu_op;
   logic        alu_z;
`ifdef ALU_ARB_PERF_EN
   logic [3:0]  perf_gnt0, perf_gnt1, perf_conf;
   int          exp_pg0, exp_pg1, exp_conf;
`endif

   int          errors = 0;
   int          checks = 0;

   // Reference state: slot contents, slot-full flags and whose turn it is on a tie.
   logic        exp_rvalid [2];
   logic [31:0] exp_c [2];
   logic        exp_z [2];
   int          mptr;
   int          last_g;
   logic        obs_r0_ready, obs_r1_ready;

   always #5 clk = ~clk;

   alu_share_arbiter #(
      .W   (32),
      .OPW (4)
`ifdef ALU_ARB_PERF_EN
      , .CNTW (4)
`endif
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .r0_valid  (r0_valid),
      .r0_ready  (r0_ready),
      .r0_a      (r0_a),
      .r0_b      (r0_b),
      .r0_op     (r0_op),
      .r0_rvalid (r0_rvalid),
      .r0_rready (r0_rready),
      .r0_c      (r0_c),
      .r0_z      (r0_z),
      .r1_valid  (r1_valid),
      .r1_ready  (r1_ready),
      .r1_a      (r1_a),
      .r1_b      (r1_b),
      .r1_op     (r1_op),
      .r1_rvalid (r1_rvalid),
      .r1_rready (r1_rready),
      .r1_c      (r1_c),
      .r1_z      (r1_z),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_c     (alu_c),
      .alu_z     (alu_z)
`ifdef ALU_ARB_PERF_EN
      , .perf_gnt0 (perf_gnt0)
      , .perf_gnt1 (perf_gnt1)
      , .perf_conf (perf_conf)
`endif
   );

   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      case (op)
         ADD:     return a + b;
         SUB:     return a - b;
         XOR:     return a ^ b;
         OR:      return a | b;
         AND:     return a & b;
         SLL:     return a << b[4:0];
         SRL:     return a >> b[4:0];
         SRA:     return 32'($signed(a) >>> b[4:0]);
         SLT:     return {31'd0, $signed(a) < $signed(b)};
         SLTU:    return {31'd0, a < b};
         default: return a ^ ~b;
      endcase
   endfunction

   // The external combinational ALU.
   always_comb begin
      alu_c = alu_ref(alu_a, alu_b, alu_op);
      alu_z = (alu_c == 32'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < 2; n++) begin
         exp_rvalid[n] = 1'b0;
         exp_c[n]      = 32'd0;
         exp_z[n]      = 1'b0;
      end
      mptr   = 0;
      last_g = -1;
`ifdef ALU_ARB_PERF_EN
      exp_pg0  = 0;
      exp_pg1  = 0;
      exp_conf = 0;
`endif
   endtask

   task automatic chk_slots();
      chk("r0_rvalid", r0_rvalid, exp_rvalid[0]);
      chk("r1_rvalid", r1_rvalid, exp_rvalid[1]);
      chk("r0_c", r0_c, exp_c[0]);
      chk("r1_c", r1_c, exp_c[1]);
      chk("r0_z", r0_z, exp_z[0]);
      chk("r1_z", r1_z, exp_z[1]);
`ifdef ALU_ARB_PERF_EN
      chk("perf_gnt0", perf_gnt0, exp_pg0);
      chk("perf_gnt1", perf_gnt1, exp_pg1);
      chk("perf_conf", perf_conf, exp_conf);
`endif
   endtask

   // One clock: check handshake and ALU pins mid-cycle, then the slots just after the edge.
   task automatic step();
      int   g;
      logic e0, e1;
      @(negedge clk);
      e0 = r0_valid && (!exp_rvalid[0] || r0_rready);
      e1 = r1_valid && (!exp_rvalid[1] || r1_rready);
      if (e0 && e1)  g = mptr;
      else if (e0)   g = 0;
      else if (e1)   g = 1;
      else           g = -1;
      obs_r0_ready = r0_ready;
      obs_r1_ready = r1_ready;
      chk("r0_ready", r0_ready, {31'd0, g == 0});
      chk("r1_ready", r1_ready, {31'd0, g == 1});
      chk("alu_a", alu_a, (g == 0) ? r0_a : (g == 1) ? r1_a : 32'd0);
      chk("alu_b", alu_b, (g == 0) ? r0_b : (g == 1) ? r1_b : 32'd0);
      chk("alu_op", alu_op, (g == 0) ? r0_op : (g == 1) ? r1_op : ADD);
      @(posedge clk);
      if (g == 0) begin
         exp_c[0] = alu_ref(r0_a, r0_b, r0_op);
         exp_z[0] = (exp_c[0] == 32'd0);
         exp_rvalid[0] = 1'b1;
      end else if (exp_rvalid[0] && r0_rready) begin
         exp_rvalid[0] = 1'b0;
      end
      if (g == 1) begin
         exp_c[1] = alu_ref(r1_a, r1_b, r1_op);
         exp_z[1] = (exp_c[1] == 32'd0);
         exp_rvalid[1] = 1'b1;
      end else if (exp_rvalid[1] && r1_rready) begin
         exp_rvalid[1] = 1'b0;
      end
      if (g >= 0) mptr = 1 - g;
`ifdef ALU_ARB_PERF_EN
      if (g == 0 && exp_pg0 < 15) exp_pg0++;
      if (g == 1 && exp_pg1 < 15) exp_pg1++;
      if (g >= 0 && r0_valid && r1_valid && exp_conf < 15) exp_conf++;
`endif
      last_g = g;
      #1;
      chk_slots();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      r0_valid = 1'b1;
      r1_valid = 1'b1;
      #1;
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_ready", r1_ready, 0);
      chk("rst_r0_rvalid", r0_rvalid, 0);
      chk("rst_r0_c", r0_c, 0);
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      chk_slots();
   endtask

   initial begin
      rst_n = 1'b0;
      {r0_valid, r0_rready, r1_valid, r1_rready} = '0;
      {r0_a, r0_b, r1_a, r1_b} = '0;
      r0_op = ADD;
      r1_op = ADD;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // r0 alone: 5 + 7
      r0_valid = 1'b1; r0_a = 32'd5; r0_b = 32'd7; r0_op = ADD;
      step();
      chk("add_ready", obs_r0_ready, 1);
      chk("add_c", r0_c, 32'd12);
      chk("add_z", r0_z, 0);
      chk("add_rvalid", r0_rvalid, 1);

      // r1 alone: 9 - 9, then arithmetic shift of a negative value; r0 drains meanwhile
      r0_valid = 1'b0; r0_rready = 1'b1;
      r1_valid = 1'b1; r1_a = 32'd9; r1_b = 32'd9; r1_op = SUB; r1_rready = 1'b1;
      step();
      chk("sub_c", r1_c, 32'd0);
      chk("sub_z", r1_z, 1);
      chk("r0_drained", r0_rvalid, 0);
      chk("r0_hold_c", r0_c, 32'd12);
      r1_a = 32'hFFFF_FFF0; r1_b = 32'd4; r1_op = SRA;
      step();
      chk("sra_c", r1_c, 32'hFFFF_FFFF);
      chk("sra_refill_rvalid", r1_rvalid, 1);

      // Tie from reset: r0, r1, r0, r1
      do_reset();
      r0_valid = 1'b1; r1_valid = 1'b1; r0_rready = 1'b1; r1_rready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         r0_a = 32'(i); r0_b = 32'd100; r0_op = ADD;
         r1_a = 32'(i); r1_b = 32'd1;   r1_op = SLL;
         step();
         chk("tie_r0_ready", obs_r0_ready, (i % 2 == 0));
         chk("tie_r1_ready", obs_r1_ready, (i % 2 == 1));
      end

      // r0 slot full and not consumed: r1 takes every cycle until r0 drains
      r0_rready = 1'b0;
      step();
      chk("blk_fill", obs_r0_ready, 1);
      r0_a = 32'd3; r0_b = 32'd4; r0_op = XOR;
      for (int i = 0; i < 3; i++) begin
         r1_a = 32'(i + 7);
         step();
         chk("blk_r0_ready", obs_r0_ready, 0);
         chk("blk_r1_ready", obs_r1_ready, 1);
      end
      r0_rready = 1'b1;
      step();
      chk("unblk_r0_ready", obs_r0_ready, 1);
      chk("unblk_c", r0_c, 32'd7);

      // Reset asserted in the middle of an r0 grant cycle
      r1_valid = 1'b0;
      r0_a = 32'd40; r0_b = 32'd2; r0_op = ADD;
      #2;
      chk("pre_rst_ready", r0_ready, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", r0_ready, 0);
      chk("mid_rst_rvalid", r0_rvalid, 0);
      chk("mid_rst_c", r0_c, 0);
      r0_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      chk("post_rst_rvalid", r0_rvalid, 0);
      chk("post_rst_c", r0_c, 0);
      r0_valid = 1'b1; r1_valid = 1'b1;
      step();
      chk("post_rst_tie_r0", obs_r0_ready, 1);

`ifdef ALU_ARB_PERF_EN
      do_reset();
      r0_valid = 1'b1; r1_valid = 1'b1; r0_rready = 1'b1; r1_rready = 1'b1;
      repeat (10) step();
      chk("perf_g0_10", perf_gnt0, 5);
      chk("perf_g1_10", perf_gnt1, 5);
      chk("perf_conf_10", perf_conf, 10);
      repeat (30) step();
      chk("perf_g0_sat", perf_gnt0, 4'hF);
      chk("perf_conf_sat", perf_conf, 4'hF);
`endif

      // Constrained-random traffic; an unaccepted request keeps its operands
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (!(r0_valid && last_g != 0)) begin
            r0_valid = ($urandom_range(0, 3) != 0);
            r0_a = $urandom;
            r0_b = ($urandom_range(0, 3) == 0) ? r0_a : $urandom;
            r0_op = 4'($urandom_range(0, 15));
         end
         if (!(r1_valid && last_g != 1)) begin
            r1_valid = ($urandom_range(0, 3) != 0);
            r1_a = $urandom;
            r1_b = ($urandom_range(0, 3) == 0) ? r1_a : $urandom;
            r1_op = 4'($urandom_range(0, 15));
         end
         r0_rready = 1'($urandom_range(0, 1));
         r1_rready = 1'($urandom_range(0, 1));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
